// File: rtl/processor_md_pkg.sv
// Shared ISA encodings, status codes, stall-FSM states and the execute ALU
// used by the processor_md core and its multdiv issue controller.
package processor_md_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] FN_ADD = 5'b00000;
    localparam logic [4:0] FN_SUB = 5'b00001;
    localparam logic [4:0] FN_AND = 5'b00010;
    localparam logic [4:0] FN_OR  = 5'b00011;
    localparam logic [4:0] FN_SLL = 5'b00100;
    localparam logic [4:0] FN_SRA = 5'b00101;
    localparam logic [4:0] FN_MUL = 5'b00110;
    localparam logic [4:0] FN_DIV = 5'b00111;

    localparam logic [31:0] RSTAT_ADD  = 32'd1;
    localparam logic [31:0] RSTAT_ADDI = 32'd2;
    localparam logic [31:0] RSTAT_SUB  = 32'd3;
    localparam logic [31:0] RSTAT_MUL  = 32'd4;
    localparam logic [31:0] RSTAT_DIV  = 32'd5;

    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_LINK   = 5'd31;

    typedef enum logic {
        MD_RUN  = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] result;
        logic        ovf;
    } alu_res_t;

    function automatic alu_res_t alu_exec(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [4:0]  op,
                                          input logic [4:0]  shamt);
        alu_res_t    r;
        logic [31:0] sum;
        logic [31:0] diff;
        r    = '0;
        sum  = a + b;
        diff = a - b;
        case (op)
            FN_ADD: begin
                r.result = sum;
                r.ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            FN_SUB: begin
                r.result = diff;
                r.ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            FN_AND:  r.result = a & b;
            FN_OR:   r.result = a | b;
            FN_SLL:  r.result = a << shamt;
            FN_SRA:  r.result = $signed(a) >>> shamt;
            default: r.result = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/processor_md_md_issue_ctrl.sv
// Multdiv issue/stall FSM: fires the start pulse, latches operands and the
// destination, then holds the core until the unit reports a result.
module md_issue_ctrl
    import processor_md_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mul_dec_i,
    input  logic        div_dec_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic [4:0]  rd_i,
    input  logic        rdy_i,
    output logic        mult_o,
    output logic        div_o,
    output logic [31:0] opa_o,
    output logic [31:0] opb_o,
    output logic [4:0]  rd_o,
    output logic        is_div_o,
    output logic        stall_o,
    output logic        issue_o,
    output logic        done_o
);

    md_state_e   state_q, state_d;
    logic [31:0] opa_q, opb_q;
    logic [4:0]  rd_q;
    logic        is_div_q;

    always_comb begin
        state_d = state_q;
        mult_o  = 1'b0;
        div_o   = 1'b0;
        issue_o = 1'b0;
        done_o  = 1'b0;
        stall_o = 1'b0;
        case (state_q)
            MD_RUN: begin
                if (mul_dec_i || div_dec_i) begin
                    issue_o = 1'b1;
                    mult_o  = mul_dec_i;
                    div_o   = div_dec_i;
                    state_d = MD_WAIT;
                end
            end
            MD_WAIT: begin
                stall_o = 1'b1;
                if (rdy_i) begin
                    done_o  = 1'b1;
                    state_d = MD_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= MD_RUN;
            opa_q    <= '0;
            opb_q    <= '0;
            rd_q     <= '0;
            is_div_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue_o) begin
                opa_q    <= opa_i;
                opb_q    <= opb_i;
                rd_q     <= rd_i;
                is_div_q <= div_dec_i;
            end
        end
    end

    assign opa_o    = opa_q;
    assign opb_o    = opb_q;
    assign rd_o     = rd_q;
    assign is_div_o = is_div_q;

endmodule

// File: rtl/processor_md.sv
// Single-issue core for the 5-bit-opcode ISA with stalled multi-cycle mul/div
// through an external multdiv unit and a retired-instruction counter.
module processor_md
    import processor_md_pkg::*;
#(
    parameter int unsigned IMEM_AW   = 12,
    parameter int unsigned DMEM_AW   = 12,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    output logic [IMEM_AW-1:0] address_imem,
    input  logic [31:0]        q_imem,
    output logic [DMEM_AW-1:0] address_dmem,
    output logic [31:0]        data,
    output logic               wren,
    input  logic [31:0]        q_dmem,
    output logic               ctrl_writeEnable,
    output logic [4:0]         ctrl_writeReg,
    output logic [4:0]         ctrl_readRegA,
    output logic [4:0]         ctrl_readRegB,
    output logic [31:0]        data_writeReg,
    input  logic [31:0]        data_readRegA,
    input  logic [31:0]        data_readRegB,
    output logic               ctrl_MULT,
    output logic               ctrl_DIV,
    output logic [31:0]        md_operandA,
    output logic [31:0]        md_operandB,
    input  logic [31:0]        md_result,
    input  logic               md_exception,
    input  logic               md_resultRDY,
    output logic               stall,
    output logic [31:0]        instr_retired
);

    logic [31:0] pc_q, pc_d, ret_q, ret_d, pc_inc;
    logic [4:0]  opcode, rd, rs, rt, shamt, fn;
    logic [31:0] imm_sx, tgt;
    logic        is_r, mul_dec, div_dec;
    alu_res_t    alu_res;
    logic        md_issue, md_done, md_is_div;
    logic [4:0]  md_rd;
    logic        wr_en;

    always_comb begin
        opcode = q_imem[31:27];
        rd     = q_imem[26:22];
        rs     = q_imem[21:17];
        rt     = q_imem[16:12];
        shamt  = q_imem[11:7];
        fn     = q_imem[6:2];
        imm_sx = {{15{q_imem[16]}}, q_imem[16:0]};
        tgt    = {5'b0, q_imem[26:0]};
        is_r   = (opcode == OP_RTYPE);
    end

    assign mul_dec = MULDIV_EN && is_r && (fn == FN_MUL);
    assign div_dec = MULDIV_EN && is_r && (fn == FN_DIV);

    // Branches/jr read rd on port B; bex reads the status register there.
    assign ctrl_readRegA = rs;
    assign ctrl_readRegB = is_r ? rt : ((opcode == OP_BEX) ? REG_STATUS : rd);

    assign alu_res = alu_exec(data_readRegA, is_r ? data_readRegB : imm_sx,
                              is_r ? fn : FN_ADD, shamt);

    md_issue_ctrl u_md_issue_ctrl (
        .clk_i     (clock),
        .rst_i     (reset),
        .mul_dec_i (mul_dec),
        .div_dec_i (div_dec),
        .opa_i     (data_readRegA),
        .opb_i     (data_readRegB),
        .rd_i      (rd),
        .rdy_i     (md_resultRDY),
        .mult_o    (ctrl_MULT),
        .div_o     (ctrl_DIV),
        .opa_o     (md_operandA),
        .opb_o     (md_operandB),
        .rd_o      (md_rd),
        .is_div_o  (md_is_div),
        .stall_o   (stall),
        .issue_o   (md_issue),
        .done_o    (md_done)
    );

    always_comb begin
        pc_inc        = pc_q + 32'd1;
        pc_d          = pc_q;
        ret_d         = ret_q;
        wr_en         = 1'b0;
        ctrl_writeReg = rd;
        data_writeReg = alu_res.result;
        wren          = 1'b0;
        if (md_done) begin
            pc_d  = pc_inc;
            ret_d = ret_q + 32'd1;
            wr_en = 1'b1;
            if (md_exception) begin
                ctrl_writeReg = REG_STATUS;
                data_writeReg = md_is_div ? RSTAT_DIV : RSTAT_MUL;
            end else begin
                ctrl_writeReg = md_rd;
                data_writeReg = md_result;
            end
        end else if (!stall && !md_issue) begin
            pc_d  = pc_inc;
            ret_d = ret_q + 32'd1;
            case (opcode)
                OP_RTYPE: begin
                    if (fn <= FN_SRA) begin
                        wr_en = 1'b1;
                        if (alu_res.ovf) begin
                            ctrl_writeReg = REG_STATUS;
                            data_writeReg = (fn == FN_SUB) ? RSTAT_SUB : RSTAT_ADD;
                        end
                    end
                end
                OP_ADDI: begin
                    wr_en = 1'b1;
                    if (alu_res.ovf) begin
                        ctrl_writeReg = REG_STATUS;
                        data_writeReg = RSTAT_ADDI;
                    end
                end
                OP_LW: begin
                    wr_en         = 1'b1;
                    data_writeReg = q_dmem;
                end
                OP_SW:  wren = 1'b1;
                OP_J:   pc_d = tgt;
                OP_JAL: begin
                    pc_d          = tgt;
                    wr_en         = 1'b1;
                    ctrl_writeReg = REG_LINK;
                    data_writeReg = pc_inc;
                end
                OP_JR: pc_d = data_readRegB;
                OP_BNE: begin
                    if (data_readRegB != data_readRegA) pc_d = pc_inc + imm_sx;
                end
                OP_BLT: begin
                    if ($signed(data_readRegB) < $signed(data_readRegA)) pc_d = pc_inc + imm_sx;
                end
                OP_SETX: begin
                    wr_en         = 1'b1;
                    ctrl_writeReg = REG_STATUS;
                    data_writeReg = tgt;
                end
                OP_BEX: begin
                    if (data_readRegB != '0) pc_d = tgt;
                end
                default: ;
            endcase
        end
        ctrl_writeEnable = wr_en && (ctrl_writeReg != 5'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            ret_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ret_q <= ret_d;
        end
    end

    assign address_imem  = pc_q[IMEM_AW-1:0];
    assign address_dmem  = alu_res.result[DMEM_AW-1:0];
    assign data          = data_readRegB;
    assign instr_retired = ret_q;

endmodule

// File: tb/tb_processor_md.sv
// Directed program bench for processor_md with behavioural imem, dmem,
// regfile and a hand-driven multdiv handshake.
module tb_processor_md;

    localparam logic [4:0] T_R = 5'b00000, T_J = 5'b00001, T_BNE = 5'b00010;
    localparam logic [4:0] T_JAL = 5'b00011, T_ADDI = 5'b00101, T_BLT = 5'b00110;
    localparam logic [4:0] T_SW = 5'b00111, T_LW = 5'b01000, T_SETX = 5'b10101;
    localparam logic [4:0] T_BEX = 5'b10110;
    localparam logic [4:0] F_ADD = 5'd0, F_SUB = 5'd1, F_SLL = 5'd4, F_MUL = 5'd6, F_DIV = 5'd7;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] address_imem, address_dmem;
    logic [31:0] q_imem, data, q_dmem, data_writeReg, data_readRegA, data_readRegB;
    logic        wren, ctrl_writeEnable, ctrl_MULT, ctrl_DIV, stall;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic [31:0] md_operandA, md_operandB, md_result, instr_retired;
    logic        md_exception, md_resultRDY;

    logic [31:0] imem [0:4095];
    logic [31:0] dmem [0:4095];
    logic [31:0] regs [0:31];
    logic        tb_clear;
    int unsigned wr_cnt;
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    processor_md #(.IMEM_AW(12), .DMEM_AW(12), .MULDIV_EN(1'b1)) dut (
        .clock(clock), .reset(reset),
        .address_imem(address_imem), .q_imem(q_imem),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_writeReg(data_writeReg), .data_readRegA(data_readRegA),
        .data_readRegB(data_readRegB),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_result(md_result), .md_exception(md_exception),
        .md_resultRDY(md_resultRDY),
        .stall(stall), .instr_retired(instr_retired)
    );

    assign q_imem        = imem[address_imem];
    assign q_dmem        = dmem[address_dmem];
    assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : regs[ctrl_readRegA];
    assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : regs[ctrl_readRegB];

    always @(posedge clock) begin
        if (tb_clear) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            wr_cnt <= 0;
        end else if (ctrl_writeEnable) begin
            regs[ctrl_writeReg] <= data_writeReg;
            wr_cnt <= wr_cnt + 1;
        end
        if (wren) dmem[address_dmem] <= data;
    end

    function automatic logic [31:0] enc_r(input logic [4:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] sh);
        return {T_R, rd, rs, rt, sh, fn, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input int imm);
        logic [31:0] t;
        t = imm;
        return {op, rd, rs, t[16:0]};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] op, input int unsigned tg);
        logic [31:0] t;
        t = tg;
        return {op, t[26:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    int unsigned wr0;
    int          stall_cnt, mult_cnt;

    initial begin
        reset = 1'b1; tb_clear = 1'b1;
        md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
        for (int i = 0; i < 4096; i++) imem[i] = 32'd0;
        imem[0]  = enc_i(T_ADDI, 1, 0, 5);
        imem[1]  = enc_i(T_ADDI, 2, 0, -3);
        imem[2]  = enc_r(F_ADD, 3, 1, 2, 0);
        imem[3]  = enc_i(T_ADDI, 1, 0, 6);
        imem[4]  = enc_i(T_ADDI, 2, 0, 7);
        imem[5]  = enc_i(T_BNE, 1, 2, 2);
        imem[6]  = enc_i(T_ADDI, 11, 0, 99);
        imem[7]  = enc_i(T_ADDI, 11, 0, 99);
        imem[8]  = enc_i(T_BNE, 1, 1, 5);
        imem[9]  = enc_i(T_BLT, 2, 1, 5);
        imem[10] = enc_j(T_JAL, 20);
        imem[20] = enc_j(T_SETX, 7);
        imem[21] = enc_j(T_BEX, 30);
        imem[22] = enc_j(T_J, 0);
        imem[30] = enc_i(T_BLT, 1, 2, 2);
        imem[31] = enc_i(T_ADDI, 11, 0, 99);
        imem[32] = enc_i(T_ADDI, 11, 0, 99);
        imem[33] = enc_r(F_MUL, 4, 1, 2, 0);
        imem[34] = enc_r(F_DIV, 5, 1, 0, 0);
        imem[35] = enc_i(T_ADDI, 8, 0, 1);
        imem[36] = enc_r(F_SLL, 8, 8, 0, 31);
        imem[37] = enc_i(T_ADDI, 7, 0, -1);
        imem[38] = enc_r(F_SUB, 7, 7, 8, 0);
        imem[39] = enc_i(T_ADDI, 9, 0, 1);
        imem[40] = enc_r(F_ADD, 10, 7, 9, 0);
        imem[41] = enc_i(T_SW, 3, 0, 8);
        imem[42] = enc_i(T_LW, 12, 0, 8);
        imem[43] = enc_i(T_ADDI, 0, 0, 5);
        imem[44] = enc_r(F_DIV, 13, 1, 2, 0);

        repeat (2) @(posedge clock);
        #1;
        chk("rst_pc", 32'(address_imem), 32'd0);
        chk("rst_retired", instr_retired, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mult", 32'(ctrl_MULT), 32'd0);
        chk("rst_opA", md_operandA, 32'd0);
        @(negedge clock);
        reset = 1'b0; tb_clear = 1'b0;

        tick(3);
        chk("add_pc", 32'(address_imem), 32'd3);
        chk("add_retired", instr_retired, 32'd3);
        chk("add_r3", regs[3], 32'd2);
        chk("addi_neg_r2", regs[2], 32'hFFFF_FFFD);
        tick(3);
        chk("bne_taken_pc", 32'(address_imem), 32'd8);
        tick(1);
        chk("bne_not_taken_pc", 32'(address_imem), 32'd9);
        tick(1);
        chk("blt_not_taken_pc", 32'(address_imem), 32'd10);
        tick(1);
        chk("jal_pc", 32'(address_imem), 32'd20);
        chk("jal_r31", regs[31], 32'd11);
        tick(1);
        chk("setx_r30", regs[30], 32'd7);
        tick(1);
        chk("bex_pc", 32'(address_imem), 32'd30);
        tick(1);
        chk("blt_taken_pc", 32'(address_imem), 32'd33);
        chk("skip_r11", regs[11], 32'd0);
        chk("branch_retired", instr_retired, 32'd12);

        // mul r4,r1,r2 with the result arriving in the 16th stall cycle
        chk("mul_issue_pulse", 32'(ctrl_MULT), 32'd1);
        chk("mul_issue_stall", 32'(stall), 32'd0);
        wr0 = wr_cnt;
        mult_cnt = 1;
        stall_cnt = 0;
        tick(1);
        chk("mul_opA", md_operandA, 32'd6);
        chk("mul_opB", md_operandB, 32'd7);
        for (int i = 0; i < 16; i++) begin
            if (stall) stall_cnt++;
            if (ctrl_MULT) mult_cnt++;
            if (i == 8) chk("mul_pc_hold", 32'(address_imem), 32'd33);
            if (i == 15) begin
                md_resultRDY = 1'b1;
                md_result = 32'd42;
            end
            tick(1);
        end
        md_resultRDY = 1'b0;
        chk("mul_stall_cycles", 32'(stall_cnt), 32'd16);
        chk("mul_pulse_cycles", 32'(mult_cnt), 32'd1);
        chk("mul_r4", regs[4], 32'd42);
        chk("mul_writes", 32'(wr_cnt - wr0), 32'd1);
        chk("mul_pc", 32'(address_imem), 32'd34);
        chk("mul_retired", instr_retired, 32'd13);
        chk("mul_stall_done", 32'(stall), 32'd0);

        // div r5,r1,r0: a RDY in the issue cycle must be ignored
        chk("div_issue_pulse", 32'(ctrl_DIV), 32'd1);
        md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'd99;
        tick(1);
        md_resultRDY = 1'b0; md_exception = 1'b0;
        chk("div_early_rdy_stall", 32'(stall), 32'd1);
        chk("div_early_rdy_pc", 32'(address_imem), 32'd34);
        tick(2);
        md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'd123;
        tick(1);
        md_resultRDY = 1'b0; md_exception = 1'b0;
        chk("div_exc_r30", regs[30], 32'd5);
        chk("div_exc_r5", regs[5], 32'd0);
        chk("div_pc", 32'(address_imem), 32'd35);
        chk("div_retired", instr_retired, 32'd14);

        tick(6);
        chk("sll_r8", regs[8], 32'h8000_0000);
        chk("sub_r7", regs[7], 32'h7FFF_FFFF);
        chk("add_ovf_r30", regs[30], 32'd1);
        chk("add_ovf_rd", regs[10], 32'd0);
        tick(1);
        chk("sw_mem", dmem[8], 32'd2);
        tick(1);
        chk("lw_r12", regs[12], 32'd2);
        chk("r0_we", 32'(ctrl_writeEnable), 32'd0);
        tick(1);
        chk("r0_retired", instr_retired, 32'd23);
        chk("r0_pc", 32'(address_imem), 32'd44);

        // reset in the middle of a divide, then a stale RDY
        tick(3);
        chk("wait_stall", 32'(stall), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pc", 32'(address_imem), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_retired", instr_retired, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        md_resultRDY = 1'b1; md_result = 32'd77;
        tick(1);
        md_resultRDY = 1'b0;
        chk("late_rdy_pc", 32'(address_imem), 32'd1);
        chk("late_rdy_r13", regs[13], 32'd0);
        chk("late_rdy_r30", regs[30], 32'd1);
        chk("late_rdy_stall", 32'(stall), 32'd0);
        chk("late_rdy_retired", instr_retired, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
